// File: rtl/gold_div_seq.sv
// Iterative Goldschmidt divider, Q1.15 operands, one shared 16x16 multiplier.
// Optional macro GOLD_DIV_ROUND_EN makes the multiplier rescale round-to-nearest instead of truncating.
module gold_div_seq #(
    parameter int ITERS = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] n_in,
    input  logic [15:0] d_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] result,
    output logic        out_err,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, MUL_N, MUL_D, DONE} state_t;

    state_t      state_q, state_d;
    logic [15:0] n_q, n_d;
    logic [15:0] d_q, d_d;
    logic [15:0] k_q, k_d;
    logic [3:0]  iter_q, iter_d;
    logic        err_q, err_d;
    logic        hold_q, hold_d;

    logic [15:0] mul_a;
    logic [31:0] mul_p;
    logic [15:0] mq_val;
    logic [16:0] k_diff;
    logic [15:0] k_upd;
    logic        unused_bits;

    // Initial reciprocal approximation, midpoint of each 1/16 slice of [1,2).
    function automatic logic [15:0] ia_lookup(input logic [3:0] idx);
        case (idx)
            4'd0:    return 16'd31775;
            4'd1:    return 16'd29959;
            4'd2:    return 16'd28340;
            4'd3:    return 16'd26887;
            4'd4:    return 16'd25575;
            4'd5:    return 16'd24385;
            4'd6:    return 16'd23302;
            4'd7:    return 16'd22310;
            4'd8:    return 16'd21400;
            4'd9:    return 16'd20560;
            4'd10:   return 16'd19784;
            4'd11:   return 16'd19065;
            4'd12:   return 16'd18396;
            4'd13:   return 16'd17772;
            4'd14:   return 16'd17190;
            default: return 16'd16644;
        endcase
    endfunction

    assign mul_a = (state_q == MUL_N) ? n_q : d_q;
    assign mul_p = mul_a * k_q;

`ifdef GOLD_DIV_ROUND_EN
    logic [16:0] mq_round;
    assign mq_round = {1'b0, mul_p[30:15]} + {16'd0, mul_p[14]};
    assign mq_val   = (mul_p[31] || mq_round[16]) ? 16'hFFFF : mq_round[15:0];
`else
    assign mq_val   = mul_p[31] ? 16'hFFFF : mul_p[30:15];
`endif

    assign k_diff      = 17'h10000 - {1'b0, mq_val};
    assign k_upd       = k_diff[16] ? 16'hFFFF : k_diff[15:0];
    assign unused_bits = ^{mul_p[14:0], d_in[10:0]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            n_q     <= '0;
            d_q     <= '0;
            k_q     <= '0;
            iter_q  <= '0;
            err_q   <= 1'b0;
            hold_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            d_q     <= d_d;
            k_q     <= k_d;
            iter_q  <= iter_d;
            err_q   <= err_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        d_d     = d_q;
        k_d     = k_q;
        iter_d  = iter_q;
        err_d   = err_q;
        hold_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (d_in[15]) begin
                        n_d     = n_in;
                        d_d     = d_in;
                        k_d     = ia_lookup(d_in[14:11]);
                        iter_d  = '0;
                        state_d = MUL_N;
                    end else begin
                        // Error result is presented one cycle after entering DONE.
                        n_d     = 16'hFFFF;
                        err_d   = 1'b1;
                        hold_d  = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            MUL_N: begin
                n_d     = mq_val;
                state_d = MUL_D;
            end
            MUL_D: begin
                d_d     = mq_val;
                k_d     = k_upd;
                iter_d  = iter_q + 4'd1;
                state_d = (iter_q == 4'(ITERS)) ? DONE : MUL_N;
            end
            DONE: begin
                if (out_ready && !hold_q) begin
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == DONE) && !hold_q;
    assign result    = out_valid ? n_q : 16'd0;
    assign out_err   = out_valid && err_q;

endmodule

// File: tb/tb_gold_div_seq.sv
// Scoreboard bench for gold_div_seq: expected quotients queued at accept, compared at result handshake.
module tb_gold_div_seq;

    localparam int ITERS = 2;
    localparam int LAT   = 2 * (ITERS + 1);

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] n_in = '0;
    logic [15:0] d_in = '0;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] result;
    logic        out_err;
    logic        busy;

    typedef struct {
        logic [15:0] res;
        logic        err;
        int          tol;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    gold_div_seq #(.ITERS(ITERS)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .n_in      (n_in),
        .d_in      (d_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .out_err   (out_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp, input int tol);
        n_checks++;
        if ((obs - exp <= tol) && (exp - obs <= tol))
            n_pass++;
        else
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) tol %0d", tag, obs, obs, exp, exp, tol);
    endtask

    // Ideal N/D in Q1.15, rounded, clamped to 16 bits; non-normalized divisor -> 0xFFFF.
    function automatic int ideal_q(input logic [15:0] n, input logic [15:0] d);
        longint q;
        if (!d[15]) return 32'hFFFF;
        q = (longint'(n) * 32768 + longint'(d) / 2) / longint'(d);
        if (q > 65535) q = 65535;
        return int'(q);
    endfunction

    task automatic run_txn(input logic [15:0] n, input logic [15:0] d, input int tol, input int hold);
        exp_t        e;
        int          cyc;
        logic [15:0] held;
        @(negedge clk);
        check_val("in_ready_idle", int'(in_ready), 1, 0);
        n_in     = n;
        d_in     = d;
        in_valid = 1'b1;
        e.res = 16'(ideal_q(n, d));
        e.err = !d[15];
        e.tol = d[15] ? tol : 0;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        n_in     = 16'h5A5A;
        d_in     = 16'hA5A5;
        cyc      = 0;
        while (!out_valid && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check_val("latency", cyc, d[15] ? LAT : 1, 0);
        held = result;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            n_in     = 16'h1234;
            d_in     = 16'h9000;
            @(negedge clk);
            check_val("hold_result", int'(result), int'(held), 0);
            check_val("hold_valid", int'(out_valid), 1, 0);
            check_val("hold_in_ready", int'(in_ready), 0, 0);
        end
        in_valid = 1'b0;
        e = sb.pop_front();
        check_val("result", int'(result), int'(e.res), e.tol);
        check_val("out_err", int'(out_err), int'(e.err), 0);
        $display("txn n=%h d=%h -> result=%h err=%0d latency=%0d (expect %h err=%0d)",
                 n, d, result, out_err, cyc, e.res, e.err);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_val("release_valid", int'(out_valid), 0, 0);
        check_val("release_in_ready", int'(in_ready), 1, 0);
        check_val("release_busy", int'(busy), 0, 0);
    endtask

    initial begin
        int spur;
        #1 reset = 1'b0;
        #1;
        check_val("rst_in_ready", int'(in_ready), 1, 0);
        check_val("rst_out_valid", int'(out_valid), 0, 0);
        check_val("rst_result", int'(result), 0, 0);
        check_val("rst_out_err", int'(out_err), 0, 0);
        check_val("rst_busy", int'(busy), 0, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        run_txn(16'h8000, 16'h8000, 1, 0);
        run_txn(16'h4000, 16'hC000, 2, 0);
        run_txn(16'hFFFF, 16'h8001, 2, 0);
        run_txn(16'h4000, 16'h4000, 0, 0);
        run_txn(16'h6000, 16'hA000, 2, 5);
        run_txn(16'h2000, 16'h1000, 0, 3);

        // Abort a transaction while it sits in MUL_D.
        @(negedge clk);
        n_in     = 16'h4000;
        d_in     = 16'hC000;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check_val("busy_mul_d", int'(busy), 1, 0);
        #2 reset = 1'b0;
        #1;
        check_val("abort_in_ready", int'(in_ready), 1, 0);
        check_val("abort_out_valid", int'(out_valid), 0, 0);
        check_val("abort_result", int'(result), 0, 0);
        check_val("abort_out_err", int'(out_err), 0, 0);
        check_val("abort_busy", int'(busy), 0, 0);
        sb.delete();
        @(negedge clk);
        reset = 1'b1;
        spur = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) spur++;
        end
        check_val("no_stale_result", spur, 0, 0);

        run_txn(16'h8000, 16'h8000, 1, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/gold_div_seq.md
# gold_div_seq

Self-contained iterative Goldschmidt divider for 16-bit Q1.15 operands. It is the driving end of the division datapath: it accepts N/D pairs over a valid/ready handshake and looks up the initial approximation IA. It sequences a single shared 16x16 multiplier through the N and D update steps, then returns the quotient over a second valid/ready handshake. Bench vectors use the same N/D/answer format as the existing division vectors.

## Interface
- `ITERS`, default 2: number of refinement iterations after the IA step; legal range 1..7.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  N/D offered.
- `in_ready`  out  1  block can accept a new pair.
- `n_in`  in  16  dividend, Q1.15 unsigned.
- `d_in`  in  16  divisor, Q1.15 unsigned, normalized to [1,2), so `d_in[15]`=1.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer takes result.
- `result`  out  16  quotient N/D, Q1.15.
- `out_err`  out  1  divisor not normalized; qualified by `out_valid`.
- `busy`  out  1  high in every state except IDLE.

## Operation
- States: IDLE, MUL_N, MUL_D, DONE.
- IDLE: `in_ready`=1.
  - A handshake (`in_valid`&`in_ready`) with `d_in[15]`=1 latches:
    - `n_reg`=`n_in`
    - `d_reg`=`d_in`
    - `k_reg`=IA[`d_in[14:11]`]
    - `iter`=0
  - It then moves to MUL_N.
- Not-normalized divisor: a handshake with `d_in[15]`=0 sets `n_reg`=16'hFFFF and `err`=1, then moves directly to DONE.
- IA ROM: 16 entries, IA[i] = round(2^15 / (1 + (i+0.5)/16)).
- MUL_N: `n_reg` <= mq(`n_reg`*`k_reg`); next state MUL_D.
- MUL_D:
  - `d_reg` <= mq(`d_reg`*`k_reg`).
  - `k_reg` <= 17'h10000 − mq(`d_reg`*`k_reg`), saturated to 16'hFFFF if it is ≥ 2^16.
  - `iter`++.
  - Next state is DONE when `iter`==`ITERS`, otherwise MUL_N.
- mq(p), for a 32-bit product p: if `p[31]`=1, saturate to 16'hFFFF; otherwise take `p[30:15]`. Rounding is set by the Configuration section.
- One multiplier is shared by MUL_N and MUL_D; the operand is selected by state.
- DONE: `out_valid`=1, `result`=`n_reg`, `out_err`=`err`. On `out_ready` the block returns to IDLE and clears `err`.
- `in_valid`, `n_in` and `d_in` are ignored in every state except IDLE.

## Timing
- Reset values:
  - `in_ready`=1 (state IDLE)
  - `out_valid`=0, `result`=0, `out_err`=0, `busy`=0
  - all internal registers 0
- Latency, normal case: the accept edge is t. `out_valid` rises after edge t+2·(`ITERS`+1). With `ITERS`=2 that is 6 cycles.
- Latency, error case: `out_valid` rises after edge t+1.
- Output hold: `result` and `out_err` stay stable while `out_valid`=1 and `out_ready`=0.
- Release: `out_valid` falls on the edge where `out_ready` is sampled high. `in_ready` rises in the same cycle.
- Throughput: no overlap between results and new inputs. The earliest next accept is the cycle after result release.
- Reset mid-operation: asserting `reset` low in any state forces IDLE and the reset values immediately, with no clock required. No stale result is emitted after reset is released.

## Configuration
- `GOLD_DIV_ROUND_EN`:
  - Defined: mq rounds to nearest by adding `p[14]` to `p[30:15]`; a carry out of the 16-bit field saturates to 16'hFFFF.
  - Undefined: mq truncates.
- Test tolerances below apply with either setting.

## Test plan
- N=16'h8000, D=16'h8000, `ITERS`=2 -> `result`=16'h8000 ±1 LSB, `out_err`=0, `out_valid` 6 cycles after accept.
- N=16'h4000, D=16'hC000 -> `result`=16'h2AAA ±2 LSB.
- N=16'hFFFF, D=16'h8001 -> `result` ≈ 16'hFFFE ±2 LSB, no wrap.
- D=16'h4000 -> `out_err`=1, `result`=16'hFFFF, `out_valid` after 1 cycle.
- Backpressure: hold `out_ready`=0 for 5 cycles after `out_valid` -> `result` is stable, `in_ready`=0, and a new `in_valid` is ignored until release.
- Drive `reset` low during MUL_D -> outputs return to reset values immediately; the next transaction after release completes normally.
